mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port synchronous memory between the pipelined CPU's instruction-fetch stage (IM_R side) and its memory stage (DM_CS/DM_R/DM_W side). It sits between the pipeline and a unified memory. It accepts one request at a time, latches it, issues it to memory, waits the fixed memory latency, and returns a registered acknowledge with read data. It drives a stall to the pipeline while any request is outstanding. Data accesses have priority, and a starvation counter guarantees fetch progress.

## Interface

Parameters:
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width.
- MEM_LAT, default 2, must be ≥1: cycles from mem_cs to valid mem_rdata.
- STARVE_MAX, default 3, must be ≥1: consecutive data grants allowed while fetch waits.

Ports:
- clk_in  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle.
- if_rdata  out  DATA_W  fetched instruction; holds its value until the next fetch ack.
- dm_cs  in  1  data request; held with the fields below stable until dm_ack.
- dm_r  in  1  read strobe.
- dm_w  in  1  write strobe.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_ack  out  1  one-cycle pulse; read or write complete.
- dm_rdata  out  DATA_W  load data, valid with dm_ack on reads; holds its value otherwise.
- dm_err  out  1  sticky; set by an illegal data request.
- mem_cs  out  1  memory command strobe; one cycle per transaction.
- mem_we  out  1  write enable, qualified by mem_cs.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_cs.
- stall  out  1  pipeline hold.

## Operation

**Legal data request.** dm_valid = dm_cs & (dm_r ^ dm_w).
- If dm_cs=1 and dm_r==dm_w, the request is never granted and dm_err sets.
- The requester must drop dm_cs to recover.

**FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if if_req or dm_valid is high, grant one requester. Latch its addr, wdata and we (dm_w for data, 0 for fetch) and the owner bit. Go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** mem_cs=1 with the latched fields. Load the wait counter with MEM_LAT. Go to WAIT.
- **WAIT:** decrement the counter each cycle. In the cycle the counter reaches 1 (the cycle MEM_LAT after ISSUE), capture mem_rdata into the owner's rdata register (reads only) and go to RESP.
- **RESP:** pulse the owner's ack. Go to IDLE. Requests are not sampled in RESP.

**Arbitration (IDLE only):**
- Only one requester active: grant it.
- Both active: grant data, unless starve_cnt == STARVE_MAX, in which case grant fetch.
- starve_cnt: +1 on each data grant made while if_req=1, saturating at STARVE_MAX. Cleared on every fetch grant, and on any data grant made while if_req=0.

**Outputs:**
- mem_* are registered. mem_we, mem_addr and mem_wdata are 0 whenever mem_cs=0.
- stall = (if_req & ~if_ack) | (dm_valid & ~dm_ack). Combinational; forced 0 while reset is low.
- dm_err is cleared only by reset.

**Reset (asynchronous, any state):**
- State to IDLE; starve_cnt, wait counter and latched fields to 0.
- All outputs 0: if_ack, dm_ack, if_rdata, dm_rdata, dm_err, mem_cs, mem_we, mem_addr, mem_wdata, stall.
- An in-flight transaction is abandoned. No ack is ever issued for it.

## Timing

- Request high in IDLE cycle N → mem_cs in N+1 → mem_rdata captured in N+1+MEM_LAT → ack in N+2+MEM_LAT.
- Total latency is MEM_LAT+2 cycles after the grant cycle.
- Back-to-back: a request held high through the ack cycle is granted in the cycle after RESP. Peak throughput is one transaction per MEM_LAT+3 cycles.
- Request changes before ack are ignored; fields are latched at grant.
- A requester that drops its request before ack still receives the ack.
- Writes complete with dm_ack at the same latency as reads.

## Test plan

Benches run with MEM_LAT=2 and STARVE_MAX=3; the memory model returns mem_rdata = address + 0x1000.

1. **Single fetch.** if_req=1 with if_addr=0x40 at cycle 0 → mem_cs=1 with mem_addr=0x40 and mem_we=0 at cycle 1 → if_ack=1 with if_rdata=0x1040 at cycle 4. stall is 1 in cycles 0–3.
2. **Load/store.** dm_w=1, dm_addr=0x80, dm_wdata=0xDEADBEEF → mem_we=1 with those values for exactly one cycle, then dm_ack 3 cycles later. A following dm_r at 0x80 → dm_rdata=0x1080.
3. **Simultaneous requests.** Fetch and data raised together in IDLE → data is served first. Fetch is granted in the cycle after dm_ack and acked 4 cycles later.
4. **Starvation.** dm_cs held continuously with if_req=1 → exactly 3 data transactions, then 1 fetch, then data resumes. Check the mem_cs sequence D,D,D,I,D,…
5. **Illegal request.** dm_cs=1 with dm_r=dm_w=1 → no mem_cs, dm_err=1 and stays 1, stall=0, fetch still served. After dm_cs is dropped, dm_err remains 1 until reset.
6. **Reset mid-operation.** reset low in the WAIT state → all outputs 0 immediately, no ack follows. After reset is released, a new request completes with normal latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data access.
// One transaction in flight at a time; data wins unless fetch has been passed over STARVE_MAX times.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_cs,
  input  logic              dm_r,
  input  logic              dm_w,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dm_err_q, dm_err_d;

  logic dm_valid;
  logic dm_illegal;
  logic grant_dm;
  logic grant_if;

  always_comb begin
    dm_valid   = dm_cs & (dm_r ^ dm_w);
    dm_illegal = dm_cs & ~(dm_r ^ dm_w);
    grant_dm   = dm_valid & (~if_req | (starve_q != STV_W'(STARVE_MAX)));
    grant_if   = if_req & ~grant_dm;

    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    dm_err_d    = dm_err_q | dm_illegal;

    case (state_q)
      IDLE: begin
        if (grant_dm || grant_if) begin
          state_d     = ISSUE;
          owner_d     = grant_dm;
          we_d        = grant_dm & dm_w;
          mem_cs_d    = 1'b1;
          mem_we_d    = grant_dm & dm_w;
          mem_addr_d  = grant_dm ? dm_addr : if_addr;
          mem_wdata_d = grant_dm ? dm_wdata : '0;
          // Fetch losing to data while waiting builds up starvation credit
          if (grant_dm && if_req) begin
            starve_d = (starve_q == STV_W'(STARVE_MAX)) ? starve_q : starve_q + STV_W'(1);
          end else begin
            starve_d = '0;
          end
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          if (owner_q) begin
            dm_ack_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      dm_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_err_q    <= dm_err_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_err    = dm_err_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // Stall is combinational so the pipeline holds in the same cycle it requests
  assign stall     = reset & ((if_req & ~if_ack_q) | (dm_valid & ~dm_ack_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-timeline model predicts every
// memory command and acknowledge; a monitor compares the DUT against those predictions.
module tb_mem_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_cs, dm_r, dm_w;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          dm_err;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_in(clk_in), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Memory: returns address + 0x1000, MEM_LAT cycles after the command
  logic [DW-1:0] mem_pipe [MEM_LAT];
  always @(posedge clk_in) begin
    mem_pipe[0] <= mem_cs ? mem_addr + 32'h1000 : '0;
    for (int i = 1; i < MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_rdata = mem_pipe[MEM_LAT-1];

  typedef struct {int cyc; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata;} mem_e_t;
  typedef struct {int cyc; bit dm; logic [DW-1:0] rdata;} ack_e_t;

  mem_e_t mem_q[$];
  ack_e_t ack_q[$];
  bit     log_en = 0;
  bit     log_q[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
  endtask

  task automatic fail_timeout(input string nm);
    n_total++;
    $display("FAIL %s at cycle %0d: got no response, expected one within 64 cycles", nm, cyc);
  endtask

  // Reference model: one transaction occupies the port for MEM_LAT+3 cycles from grant
  int            starve = 0;
  int            next_free = 0;
  bit            err_seen = 0;
  bit            err_now = 0;
  logic [DW-1:0] last_dm_rd = '0;

  always @(negedge clk_in) begin
    mem_e_t me;
    ack_e_t ae;
    if (!reset) begin
      mem_q.delete();
      ack_q.delete();
      starve = 0; next_free = 0; err_seen = 0; err_now = 0; last_dm_rd = '0;
    end else begin
      err_now = err_seen;
      if (dm_cs && (dm_r == dm_w)) err_seen = 1;
      if (cyc >= next_free) begin
        if (dm_cs && (dm_r != dm_w) && (!if_req || starve < STARVE_MAX)) begin
          starve = if_req ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
          me.cyc = cyc + 1; me.addr = dm_addr; me.we = dm_w; me.wdata = dm_wdata;
          if (dm_r) last_dm_rd = dm_addr + 32'h1000;
          ae.cyc = cyc + MEM_LAT + 2; ae.dm = 1'b1; ae.rdata = last_dm_rd;
          mem_q.push_back(me); ack_q.push_back(ae);
          next_free = cyc + MEM_LAT + 3;
        end else if (if_req) begin
          starve = 0;
          me.cyc = cyc + 1; me.addr = if_addr; me.we = 1'b0; me.wdata = '0;
          ae.cyc = cyc + MEM_LAT + 2; ae.dm = 1'b0; ae.rdata = if_addr + 32'h1000;
          mem_q.push_back(me); ack_q.push_back(ae);
          next_free = cyc + MEM_LAT + 3;
        end
      end
    end
  end

  // Monitor
  logic [DW-1:0] cur_if = '0;
  logic [DW-1:0] cur_dm = '0;

  always @(negedge clk_in) begin
    mem_e_t me;
    ack_e_t ae;
    bit ei, ed;
    logic es;
    #1;
    if (!reset) begin
      chk("reset_outputs", {54'd0, if_ack, dm_ack, dm_err, mem_cs, mem_we, stall,
                            |if_rdata, |dm_rdata, |mem_addr, |mem_wdata}, 64'd0);
      cur_if = '0;
      cur_dm = '0;
    end else begin
      ei = (ack_q.size() > 0) && (ack_q[0].cyc == cyc) && !ack_q[0].dm;
      ed = (ack_q.size() > 0) && (ack_q[0].cyc == cyc) && ack_q[0].dm;
      es = (if_req & ~ei) | ((dm_cs & (dm_r ^ dm_w)) & ~ed);
      chk("stall", stall, es);
      if (mem_cs) begin
        if (log_en) log_q.push_back(mem_addr == 32'h48);
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_cs", mem_cs, 1'b0);
        end else begin
          me = mem_q.pop_front();
          chk("mem_cs_cycle", cyc, me.cyc);
          chk("mem_addr", mem_addr, me.addr);
          chk("mem_we", mem_we, me.we);
          chk("mem_wdata", mem_wdata, me.wdata);
        end
      end else begin
        chk("mem_idle_zero", {mem_we, mem_addr, mem_wdata}, 64'd0);
        if (mem_q.size() > 0 && mem_q[0].cyc <= cyc) begin
          chk("missing_mem_cs", mem_cs, 1'b1);
          void'(mem_q.pop_front());
        end
      end
      chk("if_ack", if_ack, ei);
      chk("dm_ack", dm_ack, ed);
      if (ei || ed) begin
        ae = ack_q.pop_front();
        if (ae.dm) cur_dm = ae.rdata;
        else cur_if = ae.rdata;
      end
      chk("if_rdata", if_rdata, cur_if);
      chk("dm_rdata", dm_rdata, cur_dm);
      chk("dm_err", dm_err, err_now);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic if_txn(input logic [AW-1:0] a);
    bit got = 0;
    if_req = 1'b1;
    if_addr = a;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_in);
      if (if_ack) begin got = 1; break; end
    end
    if (!got) fail_timeout("if_ack_timeout");
    tick();
  endtask

  task automatic dm_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bit got = 0;
    dm_cs = 1'b1; dm_r = ~wr; dm_w = wr;
    dm_addr = a; dm_wdata = wd;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_in);
      if (dm_ack) begin got = 1; break; end
    end
    if (!got) fail_timeout("dm_ack_timeout");
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_pat [5];
    bit got;
    exp_pat[0] = 0; exp_pat[1] = 0; exp_pat[2] = 0; exp_pat[3] = 1; exp_pat[4] = 0;
    reset = 1'b0; if_req = 0; if_addr = '0;
    dm_cs = 0; dm_r = 0; dm_w = 0; dm_addr = '0; dm_wdata = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Single fetch
    if_txn(32'h40);
    if_req = 0;
    chk("fetch_0x40", if_rdata, 32'h1040);
    tick();

    // Store then load
    dm_txn(1'b1, 32'h80, 32'hDEADBEEF);
    dm_cs = 0; dm_w = 0;
    tick();
    dm_txn(1'b0, 32'h80, '0);
    dm_cs = 0; dm_r = 0;
    chk("load_0x80", dm_rdata, 32'h1080);
    tick();

    // Simultaneous requests
    fork
      begin if_txn(32'h44); if_req = 0; end
      begin dm_txn(1'b0, 32'h90, '0); dm_cs = 0; dm_r = 0; end
    join
    repeat (2) tick();

    // Starvation: continuous data with a waiting fetch
    log_en = 1;
    fork
      begin if_txn(32'h48); if_req = 0; end
      begin
        for (int i = 0; i < 5; i++) dm_txn(1'b0, 32'h200 + 32'(i * 4), '0);
        dm_cs = 0; dm_r = 0;
      end
    join
    log_en = 0;
    chk("starve_seq_len_ok", log_q.size() >= 5, 1'b1);
    if (log_q.size() >= 5)
      for (int i = 0; i < 5; i++) chk($sformatf("starve_seq_%0d", i), log_q[i], exp_pat[i]);
    repeat (2) tick();

    // Illegal data request
    dm_cs = 1; dm_r = 1; dm_w = 1; dm_addr = 32'h300;
    tick();
    if_txn(32'h4C);
    if_req = 0;
    repeat (2) tick();
    dm_cs = 0; dm_r = 0; dm_w = 0;
    repeat (3) tick();
    chk("dm_err_sticky", dm_err, 1'b1);

    // Reset during WAIT
    if_req = 1; if_addr = 32'h60;
    got = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_in);
      if (mem_cs) begin got = 1; break; end
    end
    if (!got) fail_timeout("mem_cs_before_reset");
    @(posedge clk_in);
    #3;
    reset = 1'b0;
    if_req = 0;
    #1;
    chk("reset_async_outputs", {if_ack, dm_ack, dm_err, mem_cs, mem_we, stall, if_rdata, mem_addr},
        64'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (6) tick();
    if_txn(32'h64);
    if_req = 0;
    tick();

    // Randomized traffic
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          int gap;
          gap = $urandom_range(0, 3);
          if (gap > 0) begin if_req = 0; repeat (gap) tick(); end
          if_txn($urandom & 32'h0000FFFC);
        end
        if_req = 0;
      end
      begin
        for (int i = 0; i < 25; i++) begin
          int gap;
          gap = $urandom_range(0, 3);
          if (gap > 0) begin dm_cs = 0; dm_r = 0; dm_w = 0; repeat (gap) tick(); end
          dm_txn(1'($urandom_range(0, 1)), ($urandom & 32'h0000FFFC) | 32'h10000, $urandom);
        end
        dm_cs = 0; dm_r = 0; dm_w = 0;
      end
    join
    repeat (8) tick();
    chk("pending_at_end", mem_q.size() + ack_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
